// File: rtl/mesi_isc_broad_pkg.sv
// Shared encodings and the FIFO entry layout for the MESI broadcast unit.
// Entry fields are sized for the largest supported configuration; the top
// zero-extends requests on the way in and truncates on the way out.
package mesi_isc_broad_pkg;

  localparam int ADDR_MAX_W   = 64;
  localparam int TYPE_MAX_W   = 4;
  localparam int CPU_ID_MAX_W = 4;   // CPU_COUNT is at most 16
  localparam int ID_MAX_W     = 16;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_WR_SNOOP = 3'd1,
    CMD_RD_SNOOP = 3'd2,
    CMD_EN_WR    = 3'd3,
    CMD_EN_RD    = 3'd4
  } cbus_cmd_e;

  typedef enum logic [1:0] {
    BROAD_NOP = 2'd0,
    BROAD_WR  = 2'd1,
    BROAD_RD  = 2'd2
  } broad_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_MAX_W-1:0]   addr;
    logic [TYPE_MAX_W-1:0]   btype;
    logic [CPU_ID_MAX_W-1:0] cpu_id;
    logic [ID_MAX_W-1:0]     id;
  } broad_entry_t;

  // Only WR and RD requests go through the snoop/grant handshake.
  function automatic logic is_req(input logic [TYPE_MAX_W-1:0] t);
    return (t == TYPE_MAX_W'(BROAD_WR)) || (t == TYPE_MAX_W'(BROAD_RD));
  endfunction

endpackage

// File: rtl/mesi_isc_broad_fifo.sv
// Request FIFO for the broadcast unit. Head is read straight from storage,
// so a push becomes visible at the head the cycle after it is sampled.
// Pointers carry an extra MSB so full and empty are never ambiguous.
module mesi_isc_broad_fifo #(
  parameter type entry_t = logic [7:0],
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  entry_t                 wdata,
  input  logic                   rd,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          push, pop;

  // A full FIFO still takes a push if the head leaves in the same cycle.
  assign pop   = rd & ~empty;
  assign push  = wr & (~full | pop);
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mesi_isc_broad_mc.sv
// MESI intersection controller broadcast unit: queues broadcast requests and
// serialises each one as snoop-all-others, collect acks, grant initiator.
// Optional ack watchdog: define MESI_ISC_BROAD_TIMEOUT_EN.
module mesi_isc_broad_mc
  import mesi_isc_broad_pkg::*;
#(
  parameter int CPU_COUNT        = 4,
  parameter int CPU_ID_WIDTH     = $clog2(CPU_COUNT),
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                broad_fifo_wr_i,
  input  logic [ADDR_WIDTH-1:0]               broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]         broad_type_i,
  input  logic [CPU_ID_WIDTH-1:0]             broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]           broad_id_i,
  input  logic [CPU_COUNT-1:0]                cbus_ack_array_i,
  output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
  output logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
  output logic [BROAD_ID_WIDTH-1:0]           broad_id_o,
  output logic                                fifo_status_full_o,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level_o,
  output logic                                busy_o,
  output logic                                overflow_o,
  output logic                                timeout_o
);

  broad_entry_t wr_entry, head;
  logic         fifo_empty, fifo_full, pop;
  state_e       state_q, state_d;
  logic [CPU_COUNT-1:0] pending_q, pending_d;
  logic [CPU_COUNT-1:0] init_mask;
  logic         init_valid, init_ack, head_is_wr, overflow_q, timeout;
  logic [CPU_COUNT-1:0][CBUS_CMD_WIDTH-1:0] cmd;

  // Widen the incoming request into the common entry layout.
  always_comb begin
    wr_entry        = '0;
    wr_entry.addr   = ADDR_MAX_W'(broad_addr_i);
    wr_entry.btype  = TYPE_MAX_W'(broad_type_i);
    wr_entry.cpu_id = CPU_ID_MAX_W'(broad_cpu_id_i);
    wr_entry.id     = ID_MAX_W'(broad_id_i);
  end

  mesi_isc_broad_fifo #(
    .entry_t (broad_entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (broad_fifo_wr_i),
    .wdata (wr_entry),
    .rd    (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  // Initiator decode; an out-of-range ID yields an empty mask and no grant.
  always_comb begin
    init_valid = (32'(head.cpu_id) < CPU_COUNT);
    init_mask  = '0;
    for (int i = 0; i < CPU_COUNT; i++)
      init_mask[i] = init_valid && (32'(head.cpu_id) == i);
    init_ack   = |(cbus_ack_array_i & init_mask);
    head_is_wr = (head.btype == TYPE_MAX_W'(BROAD_WR));
  end

  // Next-state, pending mask and pop decision.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_req(head.btype)) begin
            pending_d = ~init_mask;
            state_d   = ST_SNOOP;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ST_SNOOP: begin
        pending_d = pending_q & ~cbus_ack_array_i;
        if (pending_d == '0) begin
          if (init_valid) begin
            state_d = ST_GRANT;
          end else begin
            pop     = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GRANT: begin
        if (init_ack) begin
          pop       = 1'b1;
          pending_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        pending_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
    if (timeout) begin
      pop       = 1'b1;
      pending_d = '0;
      state_d   = ST_IDLE;
    end
  end

  // FSM, pending mask and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      if (broad_fifo_wr_i && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

`ifdef MESI_ISC_BROAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q;
  logic             progress;

  // Any ack that moves the handshake forward counts as progress.
  always_comb begin
    progress = ((state_q == ST_SNOOP) && |(cbus_ack_array_i & pending_q)) ||
               ((state_q == ST_GRANT) && init_ack);
    timeout  = (state_q != ST_IDLE) && !progress &&
               (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog counter: cleared on state change, progress or while idle.
  always_ff @(posedge clk) begin
    if (!rst_n)
      wd_cnt_q <= '0;
    else if ((state_d != state_q) || progress || (state_q == ST_IDLE))
      wd_cnt_q <= '0;
    else
      wd_cnt_q <= wd_cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Per-CPU command decode from state, pending mask and head entry.
  always_comb begin
    cmd = '0;
    case (state_q)
      ST_SNOOP: begin
        for (int i = 0; i < CPU_COUNT; i++)
          if (pending_q[i])
            cmd[i] = head_is_wr ? CBUS_CMD_WIDTH'(CMD_WR_SNOOP)
                                : CBUS_CMD_WIDTH'(CMD_RD_SNOOP);
      end
      ST_GRANT: begin
        for (int i = 0; i < CPU_COUNT; i++)
          if (init_mask[i])
            cmd[i] = head_is_wr ? CBUS_CMD_WIDTH'(CMD_EN_WR)
                                : CBUS_CMD_WIDTH'(CMD_EN_RD);
      end
      default: cmd = '0;
    endcase
  end

  assign cbus_cmd_array_o   = cmd;
  assign cbus_addr_o        = fifo_empty ? '0 : head.addr[ADDR_WIDTH-1:0];
  assign broad_id_o         = fifo_empty ? '0 : head.id[BROAD_ID_WIDTH-1:0];
  assign fifo_status_full_o = fifo_full;
  assign busy_o             = (state_q != ST_IDLE);
  assign overflow_o         = overflow_q;
  assign timeout_o          = timeout;

endmodule

// File: tb/tb_mesi_isc_broad_mc.sv
// Directed bench for mesi_isc_broad_mc with CPU_COUNT=4, FIFO_DEPTH=4.
// Expected command vectors pack slice i at bits [3i+2:3i].
module tb_mesi_isc_broad_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr;
  logic [31:0] addr;
  logic [1:0]  btype;
  logic [1:0]  cpu_id;
  logic [4:0]  id;
  logic [3:0]  ack;
  logic [31:0] cbus_addr;
  logic [11:0] cmd;
  logic [4:0]  bid;
  logic        full, busy, ovf, tmo;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  mesi_isc_broad_mc #(
    .CPU_COUNT(4), .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .BROAD_TYPE_WIDTH(2),
    .BROAD_ID_WIDTH(5), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .broad_fifo_wr_i(wr), .broad_addr_i(addr),
    .broad_type_i(btype), .broad_cpu_id_i(cpu_id), .broad_id_i(id),
    .cbus_ack_array_i(ack), .cbus_addr_o(cbus_addr), .cbus_cmd_array_o(cmd),
    .broad_id_o(bid), .fifo_status_full_o(full), .fifo_level_o(level),
    .busy_o(busy), .overflow_o(ovf), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] t,
                      input logic [1:0] c, input logic [4:0] i);
    wr = 1'b1; addr = a; btype = t; cpu_id = c; id = i;
    step();
    wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; addr = '0; btype = '0; cpu_id = '0; id = '0; ack = '0;
    step(); step();
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_addr", cbus_addr, 0);
    chk("rst_id", bid, 0);
    rst_n = 1'b1;
    step();

    // WR from CPU 2: snoop 0,1,3 with acks in separate cycles, then grant.
    push(32'h100, 2'd1, 2'd2, 5'd5);
    chk("t1_level", level, 1);
    chk("t1_addr", cbus_addr, 32'h100);
    chk("t1_id", bid, 5);
    chk("t1_idle_cmd", cmd, 0);
    chk("t1_idle_busy", busy, 0);
    step();
    chk("t1_busy", busy, 1);
    chk("t1_snoop", cmd, 12'h209);
    ack = 4'b1000; step(); ack = '0;
    chk("t1_ack3", cmd, 12'h009);
    ack = 4'b0100; step(); ack = '0;
    chk("t1_nonpending_ack", cmd, 12'h009);
    ack = 4'b0001; step(); ack = '0;
    chk("t1_ack0", cmd, 12'h008);
    ack = 4'b0010; step(); ack = '0;
    chk("t1_grant", cmd, 12'h0C0);
    chk("t1_grant_level", level, 1);
    ack = 4'b0100; step(); ack = '0;
    chk("t1_done_level", level, 0);
    chk("t1_done_busy", busy, 0);
    chk("t1_done_cmd", cmd, 0);
    chk("t1_done_addr", cbus_addr, 0);

    // RD from CPU 0 with all snoop acks in one cycle.
    push(32'h2A0, 2'd2, 2'd0, 5'd7);
    step();
    chk("t2_snoop", cmd, 12'h490);
    ack = 4'b1110; step(); ack = '0;
    chk("t2_grant", cmd, 12'h004);
    ack = 4'b0001; step(); ack = '0;
    chk("t2_done_level", level, 0);
    chk("t2_done_busy", busy, 0);

    // Fill to full, overflow, then pop+push while full.
    push(32'h10, 2'd1, 2'd1, 5'd1);
    push(32'h20, 2'd1, 2'd1, 5'd2);
    push(32'h30, 2'd1, 2'd1, 5'd3);
    chk("t3_not_full", full, 0);
    push(32'h40, 2'd1, 2'd1, 5'd4);
    chk("t3_full", full, 1);
    chk("t3_level4", level, 4);
    chk("t3_no_ovf", ovf, 0);
    push(32'h50, 2'd1, 2'd1, 5'd5);
    chk("t3_ovf", ovf, 1);
    chk("t3_level_hold", level, 4);
    chk("t3_head", cbus_addr, 32'h10);
    ack = 4'b1101; step(); ack = '0;
    chk("t3_grant", cmd, 12'h018);
    ack = 4'b0010; wr = 1'b1; addr = 32'h60; btype = 2'd1; cpu_id = 2'd1; id = 5'd9;
    step();
    ack = '0; wr = 1'b0;
    chk("t3_pushpop_level", level, 4);
    chk("t3_pushpop_full", full, 1);
    chk("t3_new_head", cbus_addr, 32'h20);
    chk("t3_ovf_sticky", ovf, 1);
    step();
    chk("t3_snoop", cmd, 12'h241);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t3_rst_cmd", cmd, 0);
    chk("t3_rst_level", level, 0);
    chk("t3_rst_busy", busy, 0);
    chk("t3_rst_ovf", ovf, 0);
    chk("t3_rst_full", full, 0);

    // NOP type and type 3 are dropped in IDLE with no commands.
    push(32'h77, 2'd0, 2'd0, 5'd3);
    chk("t4_level", level, 1);
    chk("t4_cmd_a", cmd, 0);
    step();
    chk("t4_popped", level, 0);
    chk("t4_busy", busy, 0);
    chk("t4_cmd_b", cmd, 0);
    push(32'h88, 2'd3, 2'd1, 5'd4);
    step();
    chk("t4_type3_popped", level, 0);
    chk("t4_type3_cmd", cmd, 0);

    // No acks: the watchdog aborts if built, otherwise the FSM waits.
    push(32'h300, 2'd1, 2'd3, 5'd1);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (tmo) pulses++;
    end
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
    chk("t5_pulses", pulses, 1);
    chk("t5_busy", busy, 0);
    chk("t5_level", level, 0);
`else
    chk("t5_pulses", pulses, 0);
    chk("t5_busy", busy, 1);
    chk("t5_level", level, 1);
`endif
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t5_rst_cmd", cmd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesi_isc_broad_mc.md
# mesi_isc_broad_mc

Parametrised broadcast unit of the MESI intersection controller: buffers broadcast requests from the main controller in a FIFO, then serialises them onto the coherence bus for `CPU_COUNT` CPUs. Each request snoops every non-initiator CPU, collects per-CPU acks in any order, then grants the initiator. It generalises the four-CPU broadcast path in CPU count and FIFO depth, and adds FIFO level reporting, overflow detection and an optional ack watchdog.

## Interface
- `CPU_COUNT`, 4: number of CPUs on the coherence bus (2..16).
- `CPU_ID_WIDTH`, `$clog2(CPU_COUNT)`: initiator ID width.
- `CBUS_CMD_WIDTH`, 3: per-CPU command width.
- `ADDR_WIDTH`, 32: address width.
- `BROAD_TYPE_WIDTH`, 2: request type width.
- `BROAD_ID_WIDTH`, 5: broadcast ID width.
- `FIFO_DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `TIMEOUT_CYCLES`, 255: watchdog limit (used only with the timeout macro).
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous reset, active low.
- `broad_fifo_wr_i` in 1: push a request.
- `broad_addr_i` in ADDR_WIDTH: request address.
- `broad_type_i` in BROAD_TYPE_WIDTH: NOP=0, WR=1, RD=2.
- `broad_cpu_id_i` in CPU_ID_WIDTH: initiator CPU.
- `broad_id_i` in BROAD_ID_WIDTH: request ID.
- `cbus_ack_array_i` in CPU_COUNT: per-CPU ack; bit i belongs to CPU i.
- `cbus_addr_o` out ADDR_WIDTH: head-entry address.
- `cbus_cmd_array_o` out CPU_COUNT*CBUS_CMD_WIDTH: slice i is the command to CPU i.
- `broad_id_o` out BROAD_ID_WIDTH: head-entry ID.
- `fifo_status_full_o` out 1: FIFO full.
- `fifo_level_o` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `busy_o` out 1: FSM is not in IDLE.
- `overflow_o` out 1: sticky; a push was dropped.
- `timeout_o` out 1: one-cycle pulse on a watchdog abort.

## Operation
- Commands: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- FIFO:
  - Write-through-to-head; the pushed entry is visible at the head the cycle after the push.
  - A push while full with no same-cycle pop is dropped, and `overflow_o` is set until reset.
  - A push while full with a same-cycle pop is accepted.
  - Level wraps are never exposed; the pointers use an extra MSB.
- FSM states: IDLE, SNOOP, GRANT.
- IDLE:
  - FIFO non-empty and head type WR or RD: load `pending` = all CPUs except the initiator, then go to SNOOP.
  - Head type NOP or 3: pop the entry, stay in IDLE, drive no commands.
- SNOOP:
  - Each CPU i with `pending[i]` gets WR_SNOOP or RD_SNOOP by type; all other CPUs get NOP.
  - An ack sampled at an edge clears `pending[i]`.
  - Acks on non-pending bits are ignored.
  - When the next `pending` is zero, go to GRANT.
- GRANT:
  - The initiator gets EN_WR or EN_RD; all other CPUs get NOP.
  - On the initiator's ack: pop the FIFO and go to IDLE.
  - If the initiator ID ≥ CPU_COUNT, skip GRANT: pop and go to IDLE.
- `cbus_addr_o` and `broad_id_o` follow the FIFO head combinationally; they are 0 when the FIFO is empty.
- `cbus_cmd_array_o` is decoded combinationally from the state, `pending` and the head entry.

## Timing
- Reset values:
  - FIFO empty; `fifo_level_o`=0; `fifo_status_full_o`=0.
  - State IDLE; `pending`=0; `busy_o`=0.
  - All commands NOP; `overflow_o`=0; `timeout_o`=0.
  - `cbus_addr_o`=0; `broad_id_o`=0.
- Latency: push sampled at edge k, FSM enters SNOOP at edge k+1, snoop commands are driven from edge k+1. Minimum is 2 cycles from the push to the first command.
- A command holds until its ack is sampled; it is NOP from the next cycle.
- A single edge can capture several snoop acks.
- The pop happens at the same edge as the grant ack.
- IDLE always lasts at least one cycle between requests.
- Simultaneous push and pop: the level is unchanged.
- Reset mid-transaction:
  - All state and the FIFO clear.
  - Commands are NOP the cycle after the reset edge.

## Configuration
- `MESI_ISC_BROAD_TIMEOUT_EN` defined:
  - A counter runs while in SNOOP or GRANT and clears on every state change or sampled ack.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout_o`, pop the head, go to IDLE.
- Undefined:
  - No counter is built; `timeout_o` is tied to 0.
  - The FSM waits for acks indefinitely.

## Structure
- Package `mesi_isc_broad_pkg`:
  - Command and type encodings as enums.
  - The FSM state enum.
  - A packed struct for the FIFO entry (addr, type, cpu_id, id).
- Sub-module `mesi_isc_broad_fifo`:
  - Parametrised by entry type and depth.
  - Outputs: full, empty, level.
- The FSM, pending mask, decode and watchdog live in the top module.

## Test plan
- CPU_COUNT=4, push WR addr 0x100 initiator 2 id 5:
  - Snoop phase: CPUs 0, 1, 3 receive WR_SNOOP.
  - Ack CPUs 3, 0, 1 in separate cycles: each slice drops to NOP after its own ack.
  - Grant phase: CPU 2 receives EN_WR; its ack pops the entry and the level returns to 0.
- Push RD with all three snoop acks in the same cycle: GRANT follows on the next cycle with EN_RD.
- Push 5 entries back-to-back, FIFO_DEPTH=4: full asserts after the fourth push; the fifth push sets `overflow_o`; level stays 4.
- Push a NOP-type entry: it is popped in IDLE with no non-NOP command on any slice.
- `MESI_ISC_BROAD_TIMEOUT_EN` with TIMEOUT_CYCLES=8 and no acks: `timeout_o` pulses once, the entry is popped and `busy_o` falls.
- Deassert `rst_n` during SNOOP: next cycle all commands are NOP and the level is 0.
